// File: rtl/uart_pkg.sv
// Shared definitions for the uart_demo serial link.
//   - receiver FSM state encodings
//   - baud divider calculation (rounded to nearest integer)
//   - mid-bit tick index for 16x oversampling
//   - 3-input majority helper used by the bit voter
package uart_pkg;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t ST_IDLE  = 2'd0;
    localparam rx_state_t ST_START = 2'd1;
    localparam rx_state_t ST_DATA  = 2'd2;
    localparam rx_state_t ST_STOP  = 2'd3;

    // Tick index that sits in the middle of a 16-tick bit period.
    localparam int MID_TICK = 8;

    // Clock cycles per oversample tick, rounded to nearest.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud * 8) / (baud * 16);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   clear  in  synchronous restart; counter returns to 0, no tick this cycle
//   tick   out 1-cycle pulse each time the counter wraps DIV-1 -> 0
// Shared by the UART receiver and transmitter.
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // A clear realigns the phase, so the wrap that coincides with it is dropped.
    assign tick = !clear && (count == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling and valid/ready byte delivery.
//   CLK_100MHz in  system clock
//   Reset_n    in  asynchronous active-low reset
//   Rx         in  serial line, idle high, asynchronous
//   RxData     out received byte, stable while RxValid is high
//   RxValid    out byte available, held until RxValid & RxReady
//   RxReady    in  consumer accept
//   FrameErr   out 1-cycle pulse, stop bit sampled low
//   Overrun    out 1-cycle pulse, byte completed while previous still pending
//   Busy       out high from start-bit detect until back in IDLE
//
// state | meaning
// IDLE  | waiting for a synced 1->0 edge on Rx
// START | validating the start bit at mid-bit
// DATA  | shifting in payload bits, LSB first
// STOP  | checking stop bit, delivering or flagging
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 CLK_100MHz,
    input  logic                 Reset_n,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxValid,
    input  logic                 RxReady,
    output logic                 FrameErr,
    output logic                 Overrun,
    output logic                 Busy
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [3:0]    LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]    SAMP_A    = 4'(MID_TICK - 1);
    localparam logic [3:0]    SAMP_B    = 4'(MID_TICK);
    localparam logic [3:0]    VOTE_TICK = 4'(MID_TICK + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    rx_state_t            state;
    logic [3:0]           tick_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 s_a;
    logic                 s_b;

    logic tick;
    logic clear;
    logic fall;
    logic vote;
    logic at_vote;
    logic at_end;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall  = rx_prev & ~rx_sync;
    assign clear = (state == ST_IDLE) && fall;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk  (CLK_100MHz),
        .rst_n(Reset_n),
        .clear(clear),
        .tick (tick)
    );

    // Third vote sample is the live synced value at the vote tick itself.
    assign vote    = majority3(s_a, s_b, rx_sync);
    assign at_vote = tick && (tick_cnt == VOTE_TICK);
    assign at_end  = tick && (tick_cnt == LAST_TICK);

    always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            s_a <= 1'b1;
            s_b <= 1'b1;
        end else if (tick) begin
            if (tick_cnt == SAMP_A) s_a <= rx_sync;
            if (tick_cnt == SAMP_B) s_b <= rx_sync;
        end
    end

    always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            RxData   <= '0;
            RxValid  <= 1'b0;
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
        end else begin
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;

            // Consumer handshake; a same-cycle delivery below overrides the drop.
            if (RxValid && RxReady) RxValid <= 1'b0;

            if (state != ST_IDLE && tick) begin
                tick_cnt <= at_end ? 4'd0 : tick_cnt + 4'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (at_vote && vote) begin
                        state <= ST_IDLE;
                    end else if (at_end) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (at_vote) shift <= {vote, shift[DATA_BITS-1:1]};
                    if (at_end) begin
                        if (bit_idx == LAST_BIT) state <= ST_STOP;
                        else                     bit_idx <= bit_idx + BW'(1);
                    end
                end
                ST_STOP: begin
                    // Re-arm mid stop bit so back-to-back frames are caught.
                    if (at_vote) begin
                        state <= ST_IDLE;
                        if (!vote) begin
                            FrameErr <= 1'b1;
                        end else if (!RxValid || RxReady) begin
                            RxData  <= shift;
                            RxValid <= 1'b1;
                        end else begin
                            Overrun <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core. The divider is shortened
// (CLK_FREQ chosen so DIV rounds 4.88 -> 5) to keep the frame count high.
module tb_uart_rx_core;

    localparam int CLK_FREQ = 9000000;
    localparam int BAUD     = 115200;
    localparam int DIV      = 5;
    localparam int BIT      = DIV * 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ferr;
    logic       ovr;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_core #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .CLK_100MHz(clk),
        .Reset_n   (rst_n),
        .Rx        (rx),
        .RxData    (rx_data),
        .RxValid   (rx_valid),
        .RxReady   (rx_ready),
        .FrameErr  (ferr),
        .Overrun   (ovr),
        .Busy      (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int         n_ferr = 0, n_ovr = 0, n_both = 0, n_wide_f = 0, n_wide_o = 0;
    int         n_vhigh = 0, n_vrise = 0, n_brise = 0, n_acc = 0;
    int         valid_rise_cyc = 0;
    logic       prev_f = 1'b0, prev_o = 1'b0, prev_v = 1'b0, prev_b = 1'b0;
    logic [7:0] acc_mem [64];

    always @(negedge clk) begin
        prev_f <= ferr;
        prev_o <= ovr;
        prev_v <= rx_valid;
        prev_b <= busy;
        if (ferr)            n_ferr   <= n_ferr + 1;
        if (ovr)             n_ovr    <= n_ovr + 1;
        if (ferr && ovr)     n_both   <= n_both + 1;
        if (ferr && prev_f)  n_wide_f <= n_wide_f + 1;
        if (ovr && prev_o)   n_wide_o <= n_wide_o + 1;
        if (rx_valid)        n_vhigh  <= n_vhigh + 1;
        if (busy && !prev_b) n_brise  <= n_brise + 1;
        if (rx_valid && !prev_v) begin
            n_vrise        <= n_vrise + 1;
            valid_rise_cyc <= cyc;
        end
        if (rx_valid && rx_ready) begin
            if (n_acc < 64) acc_mem[n_acc] <= rx_data;
            n_acc <= n_acc + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val);
        start_cyc = cyc;
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT);
        end
        rx = stop_val;
        wait_clks(BIT);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_bytes;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int a0, f0, o0, v0, h0, b0, lat;
        logic [7:0] exp_q [$];
        int exp_ferr_n;

        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h3C, 1'b0, 0, 1};
        vecs[2] = '{8'h00, 1'b1, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 1, 0};
        vecs[4] = '{8'h80, 1'b1, 1, 0};
        vecs[5] = '{8'h01, 1'b0, 0, 1};

        // Reset and idle line
        rst_n    = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        check("rst_valid", rx_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_data",  rx_data, 0);
        check("rst_ferr",  ferr, 0);
        check("rst_ovr",   ovr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        f0 = n_ferr; o0 = n_ovr; b0 = n_brise;
        wait_clks(2000);
        check("idle_valid", rx_valid, 0);
        check("idle_busy",  busy, 0);
        check("idle_flags", (n_ferr - f0) + (n_ovr - o0), 0);
        check("idle_busy_rise", n_brise - b0, 0);

        // Table-driven single frames, consumer always ready
        for (int i = 0; i < 6; i++) begin
            a0 = n_acc; f0 = n_ferr; o0 = n_ovr; h0 = n_vhigh;
            send_frame(vecs[i].data, vecs[i].stop);
            wait_clks(2 * BIT);
            check($sformatf("vec%0d_bytes", i), n_acc - a0, vecs[i].exp_bytes);
            check($sformatf("vec%0d_vhigh", i), n_vhigh - h0, vecs[i].exp_bytes);
            check($sformatf("vec%0d_ferr", i),  n_ferr - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i),   n_ovr - o0, 0);
            check($sformatf("vec%0d_busy", i),  busy, 0);
            if (vecs[i].exp_bytes == 1) begin
                check($sformatf("vec%0d_data", i), acc_mem[a0], vecs[i].data);
                lat = valid_rise_cyc - start_cyc;
                check($sformatf("vec%0d_latency_%0d", i, lat),
                      (lat >= 9 * BIT && lat <= 10 * BIT), 1);
            end
        end

        // Short glitch: false start
        f0 = n_ferr; v0 = n_vrise; b0 = n_brise;
        rx = 1'b0;
        wait_clks(25);
        rx = 1'b1;
        wait_clks(2 * BIT);
        check("glitch_busy_rise", n_brise - b0, 1);
        check("glitch_busy_low",  busy, 0);
        check("glitch_no_valid",  n_vrise - v0, 0);
        check("glitch_no_ferr",   n_ferr - f0, 0);

        // Break: line low for many bits, single error, no retrigger
        f0 = n_ferr; v0 = n_vrise; b0 = n_brise;
        rx = 1'b0;
        wait_clks(14 * BIT);
        check("break_idle_while_low", busy, 0);
        rx = 1'b1;
        wait_clks(2 * BIT);
        check("break_ferr",      n_ferr - f0, 1);
        check("break_busy_rise", n_brise - b0, 1);
        check("break_no_valid",  n_vrise - v0, 0);

        // Overrun: consumer stalled over two back-to-back frames
        rx_ready = 1'b0;
        a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_clks(BIT);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_data_held",  rx_data, 8'h11);
        check("ovr_pulses",     n_ovr - o0, 1);
        check("ovr_no_ferr",    n_ferr - f0, 0);
        rx_ready = 1'b1;
        wait_clks(1);
        check("ovr_valid_drop", rx_valid, 0);
        check("ovr_accepted",   n_acc - a0, 1);
        check("ovr_acc_data",   acc_mem[a0], 8'h11);

        // Reset during bit 4 of 0x55, then a clean 0x0F
        a0 = n_acc; f0 = n_ferr; o0 = n_ovr; v0 = n_vrise;
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0);
            wait_clks(BIT);
        end
        rx = 1'b1;
        wait_clks(BIT / 2);
        check("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #2;
        check("midrst_busy", busy, 0);
        check("midrst_valid", rx_valid, 0);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(BIT);
        check("midrst_no_flags", (n_ferr - f0) + (n_ovr - o0), 0);
        check("midrst_no_valid", n_vrise - v0, 0);
        send_frame(8'h0F, 1'b1);
        wait_clks(2 * BIT);
        check("midrst_bytes", n_acc - a0, 1);
        check("midrst_data",  acc_mem[a0], 8'h0F);
        check("midrst_flags", (n_ferr - f0) + (n_ovr - o0), 0);

        // Random frames against a reference of what the line carried
        a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
        exp_ferr_n = 0;
        for (int k = 0; k < 10; k++) begin
            logic [7:0] d;
            logic       s;
            int         gap;
            d   = 8'($urandom_range(0, 255));
            s   = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(0, 2) * (BIT / 2);
            // A low stop bit merges with the next start bit; real senders idle first.
            if (!s) gap = BIT;
            send_frame(d, s);
            if (s) exp_q.push_back(d);
            else   exp_ferr_n++;
            wait_clks(gap);
        end
        wait_clks(2 * BIT);
        check("rand_bytes", n_acc - a0, exp_q.size());
        check("rand_ferr",  n_ferr - f0, exp_ferr_n);
        check("rand_ovr",   n_ovr - o0, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("rand_data%0d", k), acc_mem[a0 + k], exp_q[k]);
        end

        // Pulse shape invariants over the whole run
        check("ferr_width",  n_wide_f, 0);
        check("ovr_width",   n_wide_o, 0);
        check("flags_apart", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
